// File: rtl/ysyx_220053_lsu.sv
// Load/store unit: accepts one EXU access at a time, issues a single
// doubleword-aligned memory request, and returns the extracted load data.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a new request (in_ready=1)
// REQ   | memory request presented, held stable until mem_req_ready
// WAIT  | request accepted, waiting for mem_rsp_valid
// RESP  | one-cycle out_valid pulse, result/error registered
module ysyx_220053_lsu #(
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [2:0]  in_memop,
    input  logic        in_wen,
    output logic        out_valid,
    output logic [63:0] out_rdata,
    output logic        out_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [2:0]  memop_q, memop_d;
    logic        wen_q, wen_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_illegal;
    logic        req_misaligned;
    logic [63:0] rsp_shifted;
    logic [63:0] load_data;
    logic [7:0]  size_mask;

    // Classify the incoming request: illegal encoding or misaligned address.
    always_comb begin
        req_illegal    = in_wen ? in_memop[2] : (in_memop == 3'b111);
        req_misaligned = 1'b0;
        if (ALIGN_CHECK != 0) begin
            case (in_memop[1:0])
                2'b01:   req_misaligned = in_addr[0];
                2'b10:   req_misaligned = |in_addr[1:0];
                2'b11:   req_misaligned = |in_addr[2:0];
                default: req_misaligned = 1'b0;
            endcase
        end
    end

    // Extract, truncate and extend the load result from the aligned doubleword.
    always_comb begin
        rsp_shifted = mem_rsp_rdata >> {addr_q[2:0], 3'b000};
        case (memop_q)
            3'b000:  load_data = {{56{rsp_shifted[7]}},  rsp_shifted[7:0]};
            3'b001:  load_data = {{48{rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'b010:  load_data = {{32{rsp_shifted[31]}}, rsp_shifted[31:0]};
            3'b011:  load_data = rsp_shifted;
            3'b100:  load_data = {56'd0, rsp_shifted[7:0]};
            3'b101:  load_data = {48'd0, rsp_shifted[15:0]};
            3'b110:  load_data = {32'd0, rsp_shifted[31:0]};
            default: load_data = 64'd0;
        endcase
    end

    // Byte-lane mask for the store size before lane positioning.
    always_comb begin
        case (memop_q[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Next-state logic and handshake outputs; request outputs are only
    // non-zero while in REQ so they read as zero in every other state.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        memop_d       = memop_q;
        wen_d         = wen_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = 64'd0;
        mem_req_wen   = 1'b0;
        mem_req_wdata = 64'd0;
        mem_req_wmask = 8'd0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    memop_d = in_memop;
                    wen_d   = in_wen;
                    if (req_illegal || req_misaligned) begin
                        err_d   = 1'b1;
                        rdata_d = 64'd0;
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {addr_q[63:3], 3'b000};
                mem_req_wen   = wen_q;
                if (wen_q) begin
                    mem_req_wdata = wdata_q << {addr_q[2:0], 3'b000};
                    mem_req_wmask = size_mask << addr_q[2:0];
                end
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    err_d   = 1'b0;
                    rdata_d = wen_q ? 64'd0 : load_data;
                    state_d = RESP;
                end
            end
            RESP: begin
                out_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            memop_q <= 3'd0;
            wen_q   <= 1'b0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            memop_q <= memop_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign out_rdata = rdata_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_220053_lsu.sv
// Directed bench for the LSU: expected results are queued when a request
// is driven and popped when out_valid is observed.
module tb_ysyx_220053_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [2:0]  in_memop;
    logic        in_wen;
    logic        out_valid;
    logic [63:0] out_rdata;
    logic        out_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;

    ysyx_220053_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_memop      (in_memop),
        .in_wen        (in_wen),
        .out_valid     (out_valid),
        .out_rdata     (out_rdata),
        .out_err       (out_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   xfer_cnt = 0;
    int   ov_cnt   = 0;

    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) xfer_cnt <= xfer_cnt + 1;
        if (out_valid) ov_cnt <= ov_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic [63:0] a, input logic [63:0] wd,
                          input logic [2:0] op, input logic w, input logic [63:0] rsp,
                          input int stall, input logic [63:0] exp_rd, input logic exp_err,
                          input logic [63:0] exp_maddr, input logic [63:0] exp_mwdata,
                          input logic [7:0] exp_mask);
        int   base;
        exp_t e;
        in_valid = 1'b1;
        in_addr  = a;
        in_wdata = wd;
        in_memop = op;
        in_wen   = w;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        sb_q.push_back('{exp_rd, exp_err});
        tick();
        in_valid = 1'b0;
        in_addr  = ~a;
        in_wdata = ~wd;
        in_memop = ~op;
        in_wen   = ~w;
        if (!exp_err) begin
            chk({tag, ".req_valid"}, 64'(mem_req_valid), 64'd1);
            chk({tag, ".req_addr"}, mem_req_addr, exp_maddr);
            chk({tag, ".req_wdata"}, mem_req_wdata, exp_mwdata);
            chk({tag, ".req_wmask"}, 64'(mem_req_wmask), 64'(exp_mask));
            chk({tag, ".req_wen"}, 64'(mem_req_wen), 64'(w));
            base = xfer_cnt;
            for (int i = 0; i < stall; i++) begin
                tick();
                chk({tag, ".stall_valid"}, 64'(mem_req_valid), 64'd1);
                chk({tag, ".stall_addr"}, mem_req_addr, exp_maddr);
            end
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            chk({tag, ".wait_valid"}, 64'(mem_req_valid), 64'd0);
            chk({tag, ".xfers"}, 64'(xfer_cnt), 64'(base + 1));
            tick();
            chk({tag, ".wait_no_out"}, 64'(out_valid), 64'd0);
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rsp;
            tick();
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        end else begin
            chk({tag, ".err_no_req"}, 64'(mem_req_valid), 64'd0);
        end
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, ".rdata"}, out_rdata, e.rdata);
            chk({tag, ".err"}, 64'(out_err), 64'(e.err));
        end else begin
            chk({tag, ".sb_empty"}, 64'd0, 64'd1);
        end
        tick();
        chk({tag, ".out_pulse"}, 64'(out_valid), 64'd0);
        chk({tag, ".rdata_hold"}, out_rdata, exp_rd);
        chk({tag, ".back_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int ov_base;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_addr       = 64'd0;
        in_wdata      = 64'd0;
        in_memop      = 3'd0;
        in_wen        = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 64'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_err", 64'(out_err), 64'd0);
        chk("rst.out_rdata", out_rdata, 64'd0);
        chk("rst.wmask", 64'(mem_req_wmask), 64'd0);
        chk("rst.req_addr", mem_req_addr, 64'd0);
        chk("rst.req_wdata", mem_req_wdata, 64'd0);
        chk("rst.req_wen", 64'(mem_req_wen), 64'd0);

        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h1234;
        tick();
        mem_rsp_valid = 1'b0;
        chk("idle_rsp.out_valid", 64'(out_valid), 64'd0);
        chk("idle_rsp.in_ready", 64'(in_ready), 64'd1);

        access("lb", 64'h8000_0003, 64'd0, 3'b000, 1'b0, 64'h1122_3344_8877_6655, 0,
               64'hFFFF_FFFF_FFFF_FF88, 1'b0, 64'h8000_0000, 64'd0, 8'h00);
        access("sh", 64'h8000_0006, 64'h5555_0000_0000_ABCD, 3'b001, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1,
               64'd0, 1'b0, 64'h8000_0000, 64'hABCD_0000_0000_0000, 8'hC0);
        access("lw_mis", 64'h8000_0002, 64'd0, 3'b010, 1'b0, 64'd0, 0,
               64'd0, 1'b1, 64'd0, 64'd0, 8'h00);
        access("ld_stall", 64'h8000_0008, 64'd0, 3'b011, 1'b0, 64'h0123_4567_89AB_CDEF, 3,
               64'h0123_4567_89AB_CDEF, 1'b0, 64'h8000_0008, 64'd0, 8'h00);
        access("lwu", 64'h8000_0004, 64'd0, 3'b110, 1'b0, 64'h89AB_CDEF_0000_0000, 0,
               64'h0000_0000_89AB_CDEF, 1'b0, 64'h8000_0000, 64'd0, 8'h00);
        access("lh", 64'h8000_0002, 64'd0, 3'b001, 1'b0, 64'h0000_0000_8001_0000, 0,
               64'hFFFF_FFFF_FFFF_8001, 1'b0, 64'h8000_0000, 64'd0, 8'h00);
        access("lhu", 64'h8000_0006, 64'd0, 3'b101, 1'b0, 64'hFEDC_0000_0000_0000, 2,
               64'h0000_0000_0000_FEDC, 1'b0, 64'h8000_0000, 64'd0, 8'h00);
        access("lw", 64'h8000_0004, 64'd0, 3'b010, 1'b0, 64'h8000_0001_0000_0000, 0,
               64'hFFFF_FFFF_8000_0001, 1'b0, 64'h8000_0000, 64'd0, 8'h00);
        access("sb", 64'h8000_0005, 64'h0000_0000_0000_0077, 3'b000, 1'b1, 64'd0, 0,
               64'd0, 1'b0, 64'h8000_0000, 64'h0000_7700_0000_0000, 8'h20);
        access("sd", 64'h8000_0010, 64'h0102_0304_0506_0708, 3'b011, 1'b1, 64'd0, 0,
               64'd0, 1'b0, 64'h8000_0010, 64'h0102_0304_0506_0708, 8'hFF);
        access("sw", 64'h8000_000C, 64'h0000_0000_CAFE_BABE, 3'b010, 1'b1, 64'd0, 0,
               64'd0, 1'b0, 64'h8000_0008, 64'hCAFE_BABE_0000_0000, 8'hF0);
        access("lbu", 64'h8000_0007, 64'd0, 3'b100, 1'b0, 64'hF0FF_FFFF_FFFF_FFFF, 0,
               64'h0000_0000_0000_00F0, 1'b0, 64'h8000_0000, 64'd0, 8'h00);
        access("ill_ld", 64'h8000_0000, 64'd0, 3'b111, 1'b0, 64'd0, 0,
               64'd0, 1'b1, 64'd0, 64'd0, 8'h00);
        access("ill_st", 64'h8000_0000, 64'hFF, 3'b100, 1'b1, 64'd0, 0,
               64'd0, 1'b1, 64'd0, 64'd0, 8'h00);
        access("ld_mis", 64'h8000_0004, 64'd0, 3'b011, 1'b0, 64'd0, 0,
               64'd0, 1'b1, 64'd0, 64'd0, 8'h00);

        // Reset while waiting for a response; the late response must vanish.
        ov_base  = ov_cnt;
        in_valid = 1'b1;
        in_addr  = 64'h8000_0001;
        in_memop = 3'b000;
        in_wen   = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("rstw.req_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("rstw.in_wait", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw.in_ready", 64'(in_ready), 64'd1);
        chk("rstw.req_valid0", 64'(mem_req_valid), 64'd0);
        chk("rstw.out_rdata", out_rdata, 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rstw.late_out", 64'(out_valid), 64'd0);
        chk("rstw.late_ready", 64'(in_ready), 64'd1);
        tick();
        chk("rstw.late_out2", 64'(out_valid), 64'd0);
        chk("rstw.ov_count", 64'(ov_cnt), 64'(ov_base));
        chk("rstw.rdata_kept", out_rdata, 64'd0);

        access("post_rst", 64'h8000_0001, 64'd0, 3'b000, 1'b0, 64'h0000_0000_0000_7F00, 0,
               64'h0000_0000_0000_007F, 1'b0, 64'h8000_0000, 64'd0, 8'h00);

        chk("sb.drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
